fmap_serializer: RTL and testbench

FMAP_SERIALIZER -- requirements
Module: fmap_serializer

---
 rtl/fmap_serializer_if.sv | 48 ++++
 rtl/fmap_serializer.sv | 143 ++++++++++++++
 tb/tb_fmap_serializer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmap_serializer_if.sv
// Frame-in / element-out bundle for fmap_serializer.
// The "master" modport is the serializer's view: it drives the element stream
// and status flags and receives the frame, dimensions, downstream ready and
// overrun clear. The "slave" modport is the environment's view of the same wires.
// Optional macro FMAP_SER_COORD_EN adds the m_ch/m_row/m_col coordinate outputs.
interface fmap_serializer_if #(
  parameter int ELEM_WIDTH     = 8,
  parameter int MAX_IMG_HEIGHT = 32,
  parameter int MAX_IMG_WIDTH  = 32,
  parameter int MAX_CHANNELS   = 16
);
  localparam int FRAME_BITS = MAX_CHANNELS * MAX_IMG_HEIGHT * MAX_IMG_WIDTH * ELEM_WIDTH;

  logic                  valid_in;
  logic [FRAME_BITS-1:0] data_in;
  logic [7:0]            img_height;
  logic [7:0]            img_width;
  logic [7:0]            channels;
  logic                  overrun_clr;
  logic                  busy;
  logic                  m_valid;
  logic                  m_ready;
  logic [ELEM_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  overrun;
  logic                  cfg_err;
`ifdef FMAP_SER_COORD_EN
  logic [7:0]            m_ch;
  logic [7:0]            m_row;
  logic [7:0]            m_col;
`endif

  modport master (
`ifdef FMAP_SER_COORD_EN
    output m_ch, m_row, m_col,
`endif
    output busy, m_valid, m_data, m_last, overrun, cfg_err,
    input  valid_in, data_in, img_height, img_width, channels, overrun_clr, m_ready
  );

  modport slave (
`ifdef FMAP_SER_COORD_EN
    input  m_ch, m_row, m_col,
`endif
    input  busy, m_valid, m_data, m_last, overrun, cfg_err,
    output valid_in, data_in, img_height, img_width, channels, overrun_clr, m_ready
  );
endinterface

// File: rtl/fmap_serializer.sv
// Feature-map serializer: captures one flat C x H x W frame on a valid_in pulse
// and streams its elements one per handshake, x fastest, then row, then channel.
// Element (c,r,x) sits at bit ((c*MAX_IMG_HEIGHT+r)*MAX_IMG_WIDTH+x)*ELEM_WIDTH.
// Optional macro FMAP_SER_COORD_EN exposes the current element's coordinates.
module fmap_serializer #(
  parameter int ELEM_WIDTH     = 8,
  parameter int MAX_IMG_HEIGHT = 32,
  parameter int MAX_IMG_WIDTH  = 32,
  parameter int MAX_CHANNELS   = 16
) (
  input logic                clk,
  input logic                rst_n,
  fmap_serializer_if.master  bus
);
  localparam int FRAME_BITS = MAX_CHANNELS * MAX_IMG_HEIGHT * MAX_IMG_WIDTH * ELEM_WIDTH;
  localparam int OFF_W      = $clog2(FRAME_BITS);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                r_state;
  logic [FRAME_BITS-1:0] r_frame;
  logic [7:0]            r_height;
  logic [7:0]            r_width;
  logic [7:0]            r_chans;
  logic [7:0]            r_c;
  logic [7:0]            r_r;
  logic [7:0]            r_x;
  logic                  r_mValid;
  logic [ELEM_WIDTH-1:0] r_mData;
  logic                  r_mLast;
  logic                  r_overrun;
  logic                  r_cfgErr;

  logic                  w_dimsOk;
  logic                  w_singleElem;
  logic [7:0]            w_nextC;
  logic [7:0]            w_nextR;
  logic [7:0]            w_nextX;
  logic                  w_nextLast;
  logic [OFF_W-1:0]      w_nextOff;

  // Every dimension must be non-zero and no larger than the storage it indexes.
  always_comb begin
    w_dimsOk = (bus.img_height != 8'd0) && (32'(bus.img_height) <= 32'(MAX_IMG_HEIGHT)) &&
               (bus.img_width  != 8'd0) && (32'(bus.img_width)  <= 32'(MAX_IMG_WIDTH))  &&
               (bus.channels   != 8'd0) && (32'(bus.channels)   <= 32'(MAX_CHANNELS));
    w_singleElem = (bus.img_height == 8'd1) && (bus.img_width == 8'd1) && (bus.channels == 8'd1);
  end

  // Coordinates, bit offset and last flag of the element after the current one.
  always_comb begin
    w_nextX = r_x + 8'd1;
    w_nextR = r_r;
    w_nextC = r_c;
    if (w_nextX == r_width) begin
      w_nextX = 8'd0;
      w_nextR = r_r + 8'd1;
      if (w_nextR == r_height) begin
        w_nextR = 8'd0;
        w_nextC = r_c + 8'd1;
      end
    end
    w_nextOff = OFF_W'(((32'(w_nextC) * 32'(MAX_IMG_HEIGHT) + 32'(w_nextR)) * 32'(MAX_IMG_WIDTH)
                        + 32'(w_nextX)) * 32'(ELEM_WIDTH));
    w_nextLast = (w_nextC == r_chans - 8'd1) && (w_nextR == r_height - 8'd1) &&
                 (w_nextX == r_width - 8'd1);
  end

  // Frame capture, element stepping, registered stream outputs and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_frame   <= '0;
      r_height  <= 8'd0;
      r_width   <= 8'd0;
      r_chans   <= 8'd0;
      r_c       <= 8'd0;
      r_r       <= 8'd0;
      r_x       <= 8'd0;
      r_mValid  <= 1'b0;
      r_mData   <= '0;
      r_mLast   <= 1'b0;
      r_overrun <= 1'b0;
      r_cfgErr  <= 1'b0;
    end else begin
      if ((r_state == S_STREAM) && bus.valid_in) begin
        r_overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
        r_overrun <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.valid_in) begin
            if (w_dimsOk) begin
              r_frame  <= bus.data_in;
              r_height <= bus.img_height;
              r_width  <= bus.img_width;
              r_chans  <= bus.channels;
              r_c      <= 8'd0;
              r_r      <= 8'd0;
              r_x      <= 8'd0;
              r_mValid <= 1'b1;
              r_mData  <= bus.data_in[ELEM_WIDTH-1:0];
              r_mLast  <= w_singleElem;
              r_state  <= S_STREAM;
            end else begin
              r_cfgErr <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (bus.m_ready) begin
            if (r_mLast) begin
              r_mValid <= 1'b0;
              r_mLast  <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_c     <= w_nextC;
              r_r     <= w_nextR;
              r_x     <= w_nextX;
              r_mData <= r_frame[w_nextOff +: ELEM_WIDTH];
              r_mLast <= w_nextLast;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state == S_STREAM);
  assign bus.m_valid = r_mValid;
  assign bus.m_data  = r_mData;
  assign bus.m_last  = r_mLast;
  assign bus.overrun = r_overrun;
  assign bus.cfg_err = r_cfgErr;
`ifdef FMAP_SER_COORD_EN
  assign bus.m_ch  = r_c;
  assign bus.m_row = r_r;
  assign bus.m_col = r_x;
`endif
endmodule

// File: tb/tb_fmap_serializer.sv
// Self-checking bench for fmap_serializer: a queue-based reference model that
// expands each accepted frame into its element sequence, a per-cycle compare
// process, directed scenarios with literal expectations, and random frames.
// Coordinate checks are compiled in when FMAP_SER_COORD_EN is defined.
module tb_fmap_serializer;
  localparam int EW    = 8;
  localparam int MH    = 32;
  localparam int MW    = 32;
  localparam int MC    = 16;
  localparam int FB    = MC * MH * MW * EW;
  localparam int OFF_W = $clog2(FB);

  typedef struct {
    logic [EW-1:0] data;
    bit            last;
    int            c;
    int            r;
    int            x;
  } elem_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fmap_serializer_if #(.ELEM_WIDTH(EW), .MAX_IMG_HEIGHT(MH), .MAX_IMG_WIDTH(MW),
                       .MAX_CHANNELS(MC)) bus ();

  fmap_serializer #(.ELEM_WIDTH(EW), .MAX_IMG_HEIGHT(MH), .MAX_IMG_WIDTH(MW),
                    .MAX_CHANNELS(MC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    checkCount = 0;
  int    errorCount = 0;
  int    readyMode  = 0;
  elem_t expQ[$];
  elem_t capQ[$];
  bit    modelBusy    = 1'b0;
  bit    modelOverrun = 1'b0;
  bit    modelCfgErr  = 1'b0;
  logic [EW-1:0] lit4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [EW-1:0] lit6 [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};

  // Compares one observed value with its required value and tallies the outcome.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [OFF_W-1:0] elemOffset(input int c, input int r, input int x);
    return OFF_W'(((c * MH + r) * MW + x) * EW);
  endfunction

  // Pulses valid_in for one cycle with the given dimensions; called at posedge+1.
  task automatic applyStimulus(input int ch, input int h, input int w);
    bus.channels   = 8'(ch);
    bus.img_height = 8'(h);
    bus.img_width  = 8'(w);
    bus.valid_in   = 1'b1;
    @(posedge clk); #1;
    bus.valid_in   = 1'b0;
  endtask

  task automatic fillRandom();
    for (int i = 0; i < FB / 32; i++) bus.data_in[OFF_W'(i * 32) +: 32] = $urandom();
  endtask

  task automatic setElem(input int c, input int r, input int x, input logic [EW-1:0] v);
    bus.data_in[elemOffset(c, r, x) +: EW] = v;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      step();
      n++;
    end
    checkOutput("idle_timeout", 32'(bus.busy), 0);
  endtask

  // Drives m_ready (and random overrun_clr) just after each rising edge.
  initial forever begin
    step();
    case (readyMode)
      1: bus.m_ready = 1'b1;
      2: bus.m_ready = ~bus.m_ready;
      3: begin
        bus.m_ready     = 1'($urandom_range(0, 1));
        bus.overrun_clr = ($urandom_range(0, 7) == 0);
      end
      default: ;
    endcase
  end

  // Per-cycle check of DUT outputs against the model, then model advance.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_busy", 32'(bus.busy), 0);
      checkOutput("rst_m_valid", 32'(bus.m_valid), 0);
      checkOutput("rst_m_last", 32'(bus.m_last), 0);
      checkOutput("rst_m_data", 32'(bus.m_data), 0);
      checkOutput("rst_overrun", 32'(bus.overrun), 0);
      checkOutput("rst_cfg_err", 32'(bus.cfg_err), 0);
`ifdef FMAP_SER_COORD_EN
      checkOutput("rst_coords", {8'd0, bus.m_ch, bus.m_row, bus.m_col}, 0);
`endif
      expQ.delete();
      modelBusy    = 1'b0;
      modelOverrun = 1'b0;
      modelCfgErr  = 1'b0;
    end else begin
      bit setOv;
      int ch, h, w;
      checkOutput("busy", 32'(bus.busy), 32'(modelBusy));
      checkOutput("m_valid", 32'(bus.m_valid), 32'(modelBusy));
      checkOutput("overrun", 32'(bus.overrun), 32'(modelOverrun));
      checkOutput("cfg_err", 32'(bus.cfg_err), 32'(modelCfgErr));
      if (modelBusy) begin
        checkOutput("m_data", 32'(bus.m_data), 32'(expQ[0].data));
        checkOutput("m_last", 32'(bus.m_last), 32'(expQ[0].last));
`ifdef FMAP_SER_COORD_EN
        checkOutput("m_ch", 32'(bus.m_ch), 32'(expQ[0].c));
        checkOutput("m_row", 32'(bus.m_row), 32'(expQ[0].r));
        checkOutput("m_col", 32'(bus.m_col), 32'(expQ[0].x));
`endif
      end
      if (bus.m_valid && bus.m_ready) begin
        elem_t o;
        o.data = bus.m_data;
        o.last = bus.m_last;
`ifdef FMAP_SER_COORD_EN
        o.c = int'(bus.m_ch);
        o.r = int'(bus.m_row);
        o.x = int'(bus.m_col);
`else
        o.c = 0;
        o.r = 0;
        o.x = 0;
`endif
        capQ.push_back(o);
      end
      setOv = modelBusy && bus.valid_in;
      if (modelBusy) begin
        if (bus.m_ready) begin
          void'(expQ.pop_front());
          if (expQ.size() == 0) modelBusy = 1'b0;
        end
      end else if (bus.valid_in) begin
        ch = int'(bus.channels);
        h  = int'(bus.img_height);
        w  = int'(bus.img_width);
        if (ch >= 1 && ch <= MC && h >= 1 && h <= MH && w >= 1 && w <= MW) begin
          for (int c = 0; c < ch; c++)
            for (int r = 0; r < h; r++)
              for (int x = 0; x < w; x++) begin
                elem_t e;
                e.data = bus.data_in[elemOffset(c, r, x) +: EW];
                e.last = (c == ch - 1) && (r == h - 1) && (x == w - 1);
                e.c = c;
                e.r = r;
                e.x = x;
                expQ.push_back(e);
              end
          modelBusy = 1'b1;
        end else begin
          modelCfgErr = 1'b1;
        end
      end
      if (setOv) modelOverrun = 1'b1;
      else if (bus.overrun_clr) modelOverrun = 1'b0;
    end
  end

  // Directed scenarios followed by randomized frames.
  initial begin
    logic [EW-1:0] firstElem;
    int n;
    bus.valid_in    = 1'b0;
    bus.data_in     = '0;
    bus.img_height  = 8'd0;
    bus.img_width   = 8'd0;
    bus.channels    = 8'd0;
    bus.overrun_clr = 1'b0;
    bus.m_ready     = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    $display("[TB] 1x2x2 frame, ready always high");
    setElem(0, 0, 0, 8'h11);
    setElem(0, 0, 1, 8'h22);
    setElem(0, 1, 0, 8'h33);
    setElem(0, 1, 1, 8'h44);
    readyMode = 1;
    bus.m_ready = 1'b1;
    capQ.delete();
    applyStimulus(1, 2, 2);
    checkOutput("lat1_m_valid", 32'(bus.m_valid), 1);
    waitIdle(50);
    checkOutput("f1_after_valid", 32'(bus.m_valid), 0);
    checkOutput("f1_count", 32'(capQ.size()), 4);
    for (int i = 0; i < 4 && i < capQ.size(); i++) begin
      checkOutput("f1_data", 32'(capQ[i].data), 32'(lit4[i]));
      checkOutput("f1_last", 32'(capQ[i].last), 32'(i == 3));
    end

    $display("[TB] 2x1x3 frame, ready toggling");
    bus.data_in = '0;
    for (int c = 0; c < 2; c++)
      for (int x = 0; x < 3; x++) setElem(c, 0, x, 8'(8'hA0 + c * 16 + x));
    bus.m_ready = 1'b0;
    readyMode = 2;
    capQ.delete();
    applyStimulus(2, 1, 3);
    waitIdle(100);
    checkOutput("f2_count", 32'(capQ.size()), 6);
    for (int i = 0; i < 6 && i < capQ.size(); i++) begin
      checkOutput("f2_data", 32'(capQ[i].data), 32'(lit6[i]));
      checkOutput("f2_last", 32'(capQ[i].last), 32'(i == 5));
    end

    $display("[TB] illegal dimensions");
    readyMode = 1;
    capQ.delete();
    applyStimulus(2, 2, 0);
    step();
    applyStimulus(17, 2, 2);
    repeat (3) step();
    checkOutput("cfg_err_set", 32'(bus.cfg_err), 1);
    checkOutput("cfg_busy", 32'(bus.busy), 0);
    checkOutput("cfg_no_elems", 32'(capQ.size()), 0);

    $display("[TB] valid_in during stream and on final handshake");
    readyMode = 0;
    bus.m_ready = 1'b1;
    fillRandom();
    firstElem = bus.data_in[EW-1:0];
    capQ.delete();
    applyStimulus(2, 3, 4);
    repeat (4) step();
    fillRandom();
    applyStimulus(1, 1, 1);
    n = 0;
    while (!bus.m_last && n < 100) begin
      step();
      n++;
    end
    checkOutput("last_timeout", 32'(bus.m_last), 1);
    bus.m_ready = 1'b0;
    repeat (2) step();
    bus.m_ready  = 1'b1;
    bus.valid_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    step();
    checkOutput("ov_busy", 32'(bus.busy), 0);
    checkOutput("ov_set", 32'(bus.overrun), 1);
    checkOutput("ov_count", 32'(capQ.size()), 24);
    if (capQ.size() == 24) begin
      checkOutput("ov_first", 32'(capQ[0].data), 32'(firstElem));
      checkOutput("ov_lastflag", 32'(capQ[23].last), 1);
    end
    bus.overrun_clr = 1'b1;
    step();
    bus.overrun_clr = 1'b0;
    checkOutput("ov_clr", 32'(bus.overrun), 0);

    $display("[TB] reset mid-frame");
    readyMode = 1;
    fillRandom();
    capQ.delete();
    applyStimulus(1, 4, 4);
    n = 0;
    while (capQ.size() < 3 && n < 50) begin
      step();
      n++;
    end
    checkOutput("rst_wait", 32'(capQ.size()), 3);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_now_valid", 32'(bus.m_valid), 0);
    checkOutput("rst_now_busy", 32'(bus.busy), 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    fillRandom();
    firstElem = bus.data_in[EW-1:0];
    capQ.delete();
    applyStimulus(1, 1, 3);
    waitIdle(50);
    checkOutput("rst_new_count", 32'(capQ.size()), 3);
    if (capQ.size() > 0) checkOutput("rst_new_first", 32'(capQ[0].data), 32'(firstElem));

    $display("[TB] random frames");
    readyMode = 3;
    for (int f = 0; f < 12; f++) begin
      int ch, h, w;
      fillRandom();
      ch = $urandom_range(1, 4);
      h  = $urandom_range(1, 6);
      w  = $urandom_range(1, 6);
      if ($urandom_range(0, 7) == 0) ch = 0;
      applyStimulus(ch, h, w);
      n = 0;
      while (bus.busy && n < 2000) begin
        bus.valid_in = ($urandom_range(0, 15) == 0);
        step();
        n++;
      end
      bus.valid_in = 1'b0;
      checkOutput("rand_timeout", 32'(bus.busy), 0);
      step();
    end
    readyMode = 0;
    bus.overrun_clr = 1'b0;

    $display("[TB] full 1x32x32 frame");
    bus.m_ready = 1'b1;
    readyMode = 1;
    fillRandom();
    capQ.delete();
    applyStimulus(1, 32, 32);
    waitIdle(1200);
    checkOutput("full_count", 32'(capQ.size()), 1024);
    if (capQ.size() == 1024) begin
      checkOutput("full_last", 32'(capQ[1023].last), 1);
`ifdef FMAP_SER_COORD_EN
      checkOutput("full_row", 32'(capQ[1023].r), 31);
      checkOutput("full_col", 32'(capQ[1023].x), 31);
      checkOutput("full_ch", 32'(capQ[1023].c), 0);
`endif
    end

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
